// File: rtl/car_light.sv
// Thunderbird-style tail-light controller: three-lamp sequential sweep per side
// plus hazard flash. Moore FSM with registered lamp outputs, stepped by a divided tick.
module car_light #(
    parameter int STEP_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [2:0] light_left,
    output logic [2:0] light_right,
    input  logic       left,
    input  logic       right,
    input  logic       E
);

    localparam int                CNT_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STEP_DIV - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        L1   = 3'd1,
        L2   = 3'd2,
        L3   = 3'd3,
        R1   = 3'd4,
        R2   = 3'd5,
        R3   = 3'd6,
        HAZ  = 3'd7
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             haz_req;

    assign tick    = (cnt == CNT_LAST);
    // Both turn stalks at once is treated as a hazard request.
    assign haz_req = E | (left & right);

    // Lamp pattern {light_left, light_right} for a given state.
    function automatic logic [5:0] lamps(input state_t s);
        logic [5:0] v;
        case (s)
            L1:      v = {3'b001, 3'b000};
            L2:      v = {3'b011, 3'b000};
            L3:      v = {3'b111, 3'b000};
            R1:      v = {3'b000, 3'b001};
            R2:      v = {3'b000, 3'b011};
            R3:      v = {3'b000, 3'b111};
            HAZ:     v = {3'b111, 3'b111};
            default: v = 6'b000000;
        endcase
        return v;
    endfunction

    always_comb begin
        state_nxt = IDLE;
        if (haz_req) begin
            state_nxt = (state == HAZ) ? IDLE : HAZ;
        end else if (left) begin
            // Any non-left state falls back to IDLE first, so sides never overlap.
            case (state)
                IDLE:    state_nxt = L1;
                L1:      state_nxt = L2;
                L2:      state_nxt = L3;
                default: state_nxt = IDLE;
            endcase
        end else if (right) begin
            case (state)
                IDLE:    state_nxt = R1;
                R1:      state_nxt = R2;
                R2:      state_nxt = R3;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            state       <= IDLE;
            light_left  <= 3'b000;
            light_right <= 3'b000;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                state                     <= state_nxt;
                {light_left, light_right} <= lamps(state_nxt);
            end
        end
    end

endmodule

// File: tb/tb_car_light.sv
// Scoreboard bench for car_light: two instances (STEP_DIV=1 and 4) driven in lockstep,
// expected lamps from a count-of-lit-lamps reference model.
module tb_car_light;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       left, right, E;
    logic [2:0] ll1, lr1, ll4, lr4;

    car_light #(.STEP_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .light_left(ll1), .light_right(lr1),
        .left(left), .right(right), .E(E)
    );

    car_light #(.STEP_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .light_left(ll4), .light_right(lr4),
        .left(left), .right(right), .E(E)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ll1, lr1, ll4, lr4;
    } exp_t;

    // mode: 0 off, 1 left sweep, 2 right sweep, 3 hazard; lit: lamps lit on active side
    typedef struct packed {
        int mode;
        int lit;
        int cnt;
    } mdl_t;

    exp_t sb_q[$];
    mdl_t m1, m4;
    int   tests = 0;
    int   fails = 0;

    function automatic mdl_t mdl_advance(mdl_t m, logic l, logic r, logic e, int div);
        mdl_t n = m;
        bit   do_step = (m.cnt == div - 1);
        n.cnt = do_step ? 0 : m.cnt + 1;
        if (do_step) begin
            if (e || (l && r)) begin
                n.mode = (m.mode == 3) ? 0 : 3;
                n.lit  = (m.mode == 3) ? 0 : 3;
            end else if (l || r) begin
                int side;
                side = l ? 1 : 2;
                if (m.mode == 0) begin
                    n.mode = side;
                    n.lit  = 1;
                end else if (m.mode == side && m.lit < 3) begin
                    n.lit = m.lit + 1;
                end else begin
                    n.mode = 0;
                    n.lit  = 0;
                end
            end else begin
                n.mode = 0;
                n.lit  = 0;
            end
        end
        return n;
    endfunction

    function automatic logic [2:0] lit_mask(int lit);
        logic [3:0] v;
        v = (4'd1 << lit) - 4'd1;
        return v[2:0];
    endfunction

    function automatic logic [2:0] lamp_l(mdl_t m);
        return (m.mode == 1 || m.mode == 3) ? lit_mask(m.lit) : 3'b000;
    endfunction

    function automatic logic [2:0] lamp_r(mdl_t m);
        return (m.mode == 2 || m.mode == 3) ? lit_mask(m.lit) : 3'b000;
    endfunction

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic reset_model();
        m1 = '{mode: 0, lit: 0, cnt: 0};
        m4 = '{mode: 0, lit: 0, cnt: 0};
    endtask

    task automatic check_reset_now(input string tag);
        check({tag, "_ll1"}, ll1, 3'b000);
        check({tag, "_lr1"}, lr1, 3'b000);
        check({tag, "_ll4"}, ll4, 3'b000);
        check({tag, "_lr4"}, lr4, 3'b000);
    endtask

    // One clock: model the edge with the inputs in force, queue the expectation.
    task automatic step();
        exp_t x;
        @(posedge clk);
        if (!rst_n) begin
            reset_model();
        end else begin
            m1 = mdl_advance(m1, left, right, E, 1);
            m4 = mdl_advance(m4, left, right, E, 4);
        end
        x.ll1 = lamp_l(m1);
        x.lr1 = lamp_r(m1);
        x.ll4 = lamp_l(m4);
        x.lr4 = lamp_r(m4);
        sb_q.push_back(x);
        @(negedge clk);
        #1;
    endtask

    task automatic set_in(input logic l, input logic r, input logic e);
        left  = l;
        right = r;
        E     = e;
    endtask

    always @(negedge clk) begin : monitor
        exp_t x;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            check("ll_div1", ll1, x.ll1);
            check("lr_div1", lr1, x.lr1);
            check("ll_div4", ll4, x.ll4);
            check("lr_div4", lr4, x.lr4);
        end
    end

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0);
        reset_model();
        #1;
        check_reset_now("por");
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a left sweep
        set_in(1'b1, 1'b0, 1'b0);
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        check_reset_now("midrst");
        repeat (2) step();
        set_in(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (3) step();

        // Left sweep held
        set_in(1'b1, 1'b0, 1'b0);
        repeat (8) step();

        // Direction switch at 011
        repeat (2) step();
        set_in(1'b0, 1'b1, 1'b0);
        repeat (4) step();

        // Hazard with E, then with both stalks
        set_in(1'b1, 1'b0, 1'b1);
        repeat (6) step();
        set_in(1'b1, 1'b1, 1'b0);
        repeat (6) step();

        // Hazard exit into left sweep
        set_in(1'b1, 1'b0, 1'b1);
        step();
        set_in(1'b1, 1'b0, 1'b0);
        repeat (5) step();

        // Right sweep long enough to see the divided step cadence
        set_in(1'b0, 1'b0, 1'b0);
        repeat (4) step();
        set_in(1'b0, 1'b1, 1'b0);
        repeat (20) step();

        // Randomised request patterns with occasional mid-run resets
        repeat (150) begin
            set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 29) == 0) begin
                rst_n = 1'b0;
                #1;
                check_reset_now("rndrst");
                step();
                rst_n = 1'b1;
            end
            repeat ($urandom_range(1, 9)) step();
        end

        set_in(1'b0, 1'b0, 1'b0);
        repeat (4) step();
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/car_light.md
Name: car_light

Overview:
- Tail-light turn-signal controller for a car (Thunderbird style), with three lamps per side.
- `left` / `right` requests produce a sequential "sweep" on the matching side. The `E` (hazard) request flashes all six lamps together.
- The block sits between the driver-switch inputs (already synchronised) and the lamp drivers.
- Outputs are decoded directly from a Moore state machine. They are glitch-free because the state is registered.

Parameters:
- STEP_DIV, default 1: clock cycles per light step. Must be >= 1. A value of 1 means one step per clock.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- light_left  output  3  left lamps; bit0 innermost, bit2 outermost; 1 = lamp on.
- light_right  output  3  right lamps; bit0 innermost, bit2 outermost; 1 = lamp on.
- left  input  1  left-turn request, level sensitive.
- right  input  1  right-turn request, level sensitive.
- E  input  1  hazard/emergency request, level sensitive.

Behaviour:
- Reset:
  - rst_n=0 immediately forces state IDLE, light_left=000, light_right=000, and clears the step counter.
  - Reset is honoured mid-sequence.
  - On deassertion, operation resumes from IDLE.
- Step tick:
  - A counter 0..STEP_DIV-1 runs freely. tick=1 when the counter equals STEP_DIV-1.
  - The state advances only on a rising clk edge with tick=1.
  - With STEP_DIV=1, tick is always 1.
- Request priority, evaluated at each tick:
  - E=1, or left=1 and right=1 together: hazard.
  - Otherwise left=1: left sweep.
  - Otherwise right=1: right sweep.
  - Otherwise: idle.
- States and outputs (light_left / light_right):

  | State | light_left | light_right |
  |---|---|---|
  | IDLE | 000 | 000 |
  | L1 | 001 | 000 |
  | L2 | 011 | 000 |
  | L3 | 111 | 000 |
  | R1 | 000 | 001 |
  | R2 | 000 | 011 |
  | R3 | 000 | 111 |
  | HAZ | 111 | 111 |

- Transitions (on tick):
  - Hazard request:
    - From any state other than HAZ: go to HAZ.
    - From HAZ: go to IDLE. This gives a 50% flash: on one step, off one step.
  - Left request:
    - IDLE -> L1 -> L2 -> L3 -> IDLE, repeating while left is held.
    - From HAZ or from any R state: go to IDLE first.
  - Right request: mirror of left (IDLE -> R1 -> R2 -> R3 -> IDLE).
  - No request: any state -> IDLE.
  - A release mid-sweep turns the lamps off at the next tick. The sweep is not completed.
- Latency: with STEP_DIV=1, a request sampled at a rising edge appears on the outputs after that same edge. Step period = STEP_DIV clocks.
- A direction change (left to right or vice versa) always passes through IDLE, so both sides are never lit simultaneously except in HAZ.
- When a hazard request is removed while in HAZ, the next tick goes to IDLE. Normal priority applies after that.
- Inputs are sampled only on tick edges. Pulses shorter than one step may be missed; this is acceptable.
- Unused state encodings recover to IDLE on the next tick.

Test Plan:
1. Reset: assert rst_n=0 mid-L2 (off-edge) -> outputs are 000/000 immediately, without waiting for a clock edge. After release with no request, outputs stay 000/000.
2. Left sweep (STEP_DIV=1): left=1 held for 8 clocks -> light_left = 001, 011, 111, 000, 001, 011, 111, 000; light_right = 000 throughout.
3. Direction switch: at light_left=011, drop left and raise right -> next edge 000/000, then light_right = 001, 011, 111; light_left stays 000.
4. Hazard priority: left=1, right=0, E=1 -> outputs alternate 111/111 and 000/000 every clock. The same alternation occurs for left=1, right=1, E=0.
5. Hazard exit: E drops while in HAZ with left=1 -> IDLE (000/000), then light_left = 001, 011, ...
6. STEP_DIV=4, right=1 -> each pattern (001, 011, 111, 000) is held exactly 4 clocks.
